conv3x3_stream: RTL and testbench

CONV3X3_STREAM -- requirements
Module: conv3x3_stream

---
 rtl/conv3x3_stream.sv | 159 +++++++++++++++
 tb/tb_conv3x3_stream.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution over a raster-order pixel stream with a runtime-loadable
// signed kernel, two-line buffering and a fixed two-cycle result latency.
module conv3x3_stream #(
    parameter  int PIXEL_W = 8,
    parameter  int COEF_W  = 8,
    parameter  int IMG_W   = 64,
    parameter  int IMG_H   = 48,
    parameter  int SHIFT   = 3,
    localparam int OUT_W   = PIXEL_W + COEF_W + 5
) (
    input  logic                     clk100,
    input  logic                     in_reset,
    input  logic                     i_valid,
    input  logic [PIXEL_W-1:0]       i_pixel,
    input  logic                     i_mode,
    input  logic                     i_coef_we,
    input  logic [3:0]               i_coef_addr,
    input  logic signed [COEF_W-1:0] i_coef_data,
    output logic                     o_valid,
    output logic [OUT_W-1:0]         o_pixel,
    output logic                     o_frame_done
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic signed [OUT_W-1:0] SAT_MAX = {{(OUT_W-PIXEL_W){1'b0}}, {PIXEL_W{1'b1}}};
    localparam logic signed [COEF_W-1:0] COEF_ONE = {{(COEF_W-1){1'b0}}, 1'b1};

    logic [COL_W-1:0]         col_q, col_d;
    logic [ROW_W-1:0]         row_q, row_d;
    logic [PIXEL_W-1:0]       lb_top_q [IMG_W];
    logic [PIXEL_W-1:0]       lb_mid_q [IMG_W];
    logic [PIXEL_W-1:0]       win_q [9];
    logic signed [COEF_W-1:0] coef_q [9];
    logic signed [COEF_W-1:0] kern_q [9];
    logic                     complete_s, last_px_s, coef_wr_s;
    logic                     valid1_q, mode1_q;
    logic signed [OUT_W-1:0]  sum_s, shifted_s, sat_s, result_s;
    logic                     o_valid_q, frame_done_q;
    logic [OUT_W-1:0]         o_pixel_q;

    // Pixel zero-extended to signed times sign-extended coefficient, exact in OUT_W bits.
    function automatic logic signed [OUT_W-1:0] mac_term(
        input logic [PIXEL_W-1:0]       px,
        input logic signed [COEF_W-1:0] cf
    );
        logic signed [OUT_W-1:0] px_ext;
        logic signed [OUT_W-1:0] cf_ext;
        px_ext = $signed({{(OUT_W-PIXEL_W){1'b0}}, px});
        cf_ext = $signed({{(OUT_W-COEF_W){cf[COEF_W-1]}}, cf});
        return px_ext * cf_ext;
    endfunction

    assign complete_s = i_valid && (col_q >= COL_W'(2)) && (row_q >= ROW_W'(2));
    assign last_px_s  = i_valid && (col_q == COL_LAST) && (row_q == ROW_LAST);
    assign coef_wr_s  = i_coef_we && (i_coef_addr <= 4'd8);

    // Raster position of the next accepted pixel.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (i_valid) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                if (row_q == ROW_LAST) begin
                    row_d = '0;
                end else begin
                    row_d = row_q + ROW_W'(1);
                end
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end else begin
            col_d = col_q;
        end
    end

    // Line buffers: top holds row-2, mid holds row-1 at each column; contents need no reset.
    always_ff @(posedge clk100) begin
        if (i_valid) begin
            lb_top_q[col_q] <= lb_mid_q[col_q];
            lb_mid_q[col_q] <= i_pixel;
        end
    end

    // Kernel MAC, arithmetic shift and clamp on the captured window.
    always_comb begin
        sum_s = '0;
        for (int k = 0; k < 9; k++) begin
            sum_s = sum_s + mac_term(win_q[k], kern_q[k]);
        end
        shifted_s = sum_s >>> SHIFT;
        if (shifted_s[OUT_W-1]) begin
            sat_s = '0;
        end else if (shifted_s > SAT_MAX) begin
            sat_s = SAT_MAX;
        end else begin
            sat_s = shifted_s;
        end
        if (mode1_q) begin
            result_s = sat_s;
        end else begin
            result_s = sum_s;
        end
    end

    // Counters, window, coefficient bank and the two-stage result pipeline.
    always_ff @(posedge clk100) begin
        if (in_reset) begin
            col_q        <= '0;
            row_q        <= '0;
            valid1_q     <= 1'b0;
            mode1_q      <= 1'b0;
            o_valid_q    <= 1'b0;
            o_pixel_q    <= '0;
            frame_done_q <= 1'b0;
            for (int k = 0; k < 9; k++) begin
                win_q[k]  <= '0;
                coef_q[k] <= COEF_ONE;
                kern_q[k] <= COEF_ONE;
            end
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            valid1_q     <= complete_s;
            frame_done_q <= last_px_s;
            o_valid_q    <= valid1_q;
            if (i_valid) begin
                for (int r = 0; r < 3; r++) begin
                    win_q[r*3]   <= win_q[r*3+1];
                    win_q[r*3+1] <= win_q[r*3+2];
                end
                win_q[2] <= lb_top_q[col_q];
                win_q[5] <= lb_mid_q[col_q];
                win_q[8] <= i_pixel;
            end
            // Kernel snapshot sees the bank before this cycle's write lands.
            if (complete_s) begin
                mode1_q <= i_mode;
                for (int k = 0; k < 9; k++) begin
                    kern_q[k] <= coef_q[k];
                end
            end
            if (coef_wr_s) begin
                coef_q[i_coef_addr] <= i_coef_data;
            end
            if (valid1_q) begin
                o_pixel_q <= result_s;
            end
        end
    end

    assign o_valid      = o_valid_q;
    assign o_pixel      = o_pixel_q;
    assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_conv3x3_stream.sv
// Directed bench for conv3x3_stream on an 8x4 image: latency, kernel timing,
// saturation, i_valid gaps, back-to-back frames and mid-frame reset.
module tb_conv3x3_stream;

    logic        clk100 = 1'b0;
    logic        in_reset;
    logic        i_valid;
    logic [7:0]  i_pixel;
    logic        i_mode;
    logic        i_coef_we;
    logic [3:0]  i_coef_addr;
    logic [7:0]  i_coef_data;
    logic        o_valid;
    logic [20:0] o_pixel;
    logic        o_frame_done;

    typedef struct {
        int val;
        int due;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   img [4][8];
    int   tb_kern [9];
    int   tcol, trow, fd_due, last_out, res_cnt;

    conv3x3_stream #(
        .PIXEL_W(8), .COEF_W(8), .IMG_W(8), .IMG_H(4), .SHIFT(3)
    ) dut (
        .clk100      (clk100),
        .in_reset    (in_reset),
        .i_valid     (i_valid),
        .i_pixel     (i_pixel),
        .i_mode      (i_mode),
        .i_coef_we   (i_coef_we),
        .i_coef_addr (i_coef_addr),
        .i_coef_data (i_coef_data),
        .o_valid     (o_valid),
        .o_pixel     (o_pixel),
        .o_frame_done(o_frame_done)
    );

    always #5 clk100 = ~clk100;

    always @(posedge clk100) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Output monitor: result values, latency, hold behaviour and frame_done timing.
    always @(negedge clk100) begin
        if (o_valid === 1'b1) begin
            res_cnt++;
            if (exp_q.size() == 0) begin
                check_eq("spurious_valid", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("latency", cyc, mon_e.due);
                check_eq("result", $signed(o_pixel), mon_e.val);
            end
            last_out = $signed(o_pixel);
        end else begin
            if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                check_eq("missing_valid", 0, 1);
                mon_e = exp_q.pop_front();
            end
            if (in_reset !== 1'b1) check_eq("hold", $signed(o_pixel), last_out);
        end
        if (o_frame_done === 1'b1 || cyc == fd_due)
            check_eq("frame_done", int'(o_frame_done), int'(cyc == fd_due));
    end

    // Reference convolution for the pixel just accepted at (trow, tcol).
    task automatic model_accept(input int px, input logic md);
        int s;
        img[trow][tcol] = px;
        if (tcol >= 2 && trow >= 2) begin
            s = 0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    s += img[trow-2+r][tcol-2+c] * tb_kern[r*3+c];
            if (md) begin
                s = s >>> 3;
                if (s < 0) s = 0;
                else if (s > 255) s = 255;
            end
            exp_q.push_back('{val: s, due: cyc + 2});
        end
        if (tcol == 7 && trow == 3) fd_due = cyc + 1;
        if (tcol == 7) begin
            tcol = 0;
            trow = (trow == 3) ? 0 : trow + 1;
        end else begin
            tcol++;
        end
    endtask

    task automatic cycle_drive(input logic v, input int px, input logic md,
                               input logic we, input int addr, input int data);
        i_valid     = v;
        i_pixel     = 8'(px);
        i_mode      = md;
        i_coef_we   = we;
        i_coef_addr = 4'(addr);
        i_coef_data = 8'(data);
        if (v) model_accept(px, md);
        if (we && addr <= 8) tb_kern[addr] = data;
        @(posedge clk100);
        #1;
        i_valid   = 1'b0;
        i_coef_we = 1'b0;
    endtask

    task automatic write_coef(input int addr, input int data);
        cycle_drive(1'b0, 0, 1'b0, 1'b1, addr, data);
    endtask

    task automatic run_frame(input int cval, input bit ramp, input bit gaps,
                             input bit rand_mode, input logic md);
        for (int i = 0; i < 32; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) cycle_drive(1'b0, 0, 1'b0, 1'b0, 0, 0);
            cycle_drive(1'b1, ramp ? i : cval,
                        rand_mode ? 1'($urandom_range(0, 1)) : md, 1'b0, 0, 0);
        end
    endtask

    task automatic drain(input string tag, input int nres);
        repeat (4) cycle_drive(1'b0, 0, 1'b0, 1'b0, 0, 0);
        check_eq({tag, "_pending"}, exp_q.size(), 0);
        check_eq({tag, "_count"}, res_cnt, nres);
        res_cnt = 0;
    endtask

    task automatic do_reset(input int ncyc);
        in_reset  = 1'b1;
        i_valid   = 1'b0;
        i_coef_we = 1'b0;
        exp_q.delete();
        tcol = 0;
        trow = 0;
        fd_due = -1;
        last_out = 0;
        for (int k = 0; k < 9; k++) tb_kern[k] = 1;
        repeat (ncyc) begin
            @(posedge clk100);
            #1;
        end
        in_reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        i_pixel = 8'd0; i_mode = 1'b0; i_coef_addr = 4'd0; i_coef_data = 8'd0;
        res_cnt = 0;
        do_reset(3);
        check_eq("rst_valid", int'(o_valid), 0);
        check_eq("rst_pixel", int'(o_pixel), 0);
        check_eq("rst_fdone", int'(o_frame_done), 0);

        // Default kernel, constant 10: every result 90; then a ramp frame back-to-back
        // with a coefficient write on a completing pixel and an out-of-range write.
        run_frame(10, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 32; i++) begin
            if (i == 19)      cycle_drive(1'b1, i, 1'b0, 1'b1, 4, 5);
            else if (i == 20) cycle_drive(1'b1, i, 1'b0, 1'b1, 9, -100);
            else              cycle_drive(1'b1, i, 1'b0, 1'b0, 0, 0);
        end
        drain("b2b", 24);

        // Centre-only kernel: each result is the centre pixel of the ramp.
        for (int k = 0; k < 9; k++) write_coef(k, (k == 4) ? 1 : 0);
        run_frame(0, 1'b1, 1'b0, 1'b0, 1'b0);
        drain("centre", 12);

        // Mixed-sign kernel, random gaps and per-pixel mode changes.
        for (int k = 0; k < 9; k++) write_coef(k, k - 4);
        run_frame(0, 1'b1, 1'b1, 1'b1, 1'b0);
        drain("gaps", 12);

        // Normalised mode: saturation high, clamp low, and an in-range value.
        for (int k = 0; k < 9; k++) write_coef(k, 127);
        run_frame(255, 1'b0, 1'b0, 1'b0, 1'b1);
        drain("sat_hi", 12);
        for (int k = 0; k < 9; k++) write_coef(k, -1);
        run_frame(255, 1'b0, 1'b0, 1'b0, 1'b1);
        drain("sat_lo", 12);
        for (int k = 0; k < 9; k++) write_coef(k, 1);
        run_frame(10, 1'b0, 1'b0, 1'b0, 1'b1);
        drain("shift", 12);

        // Reset while the result of pixel (2,2) is in flight, then a fresh frame.
        for (int k = 0; k < 9; k++) write_coef(k, 3);
        for (int i = 0; i <= 18; i++) cycle_drive(1'b1, 10, 1'b0, 1'b0, 0, 0);
        res_cnt = 0;
        do_reset(2);
        check_eq("midrst_valid", int'(o_valid), 0);
        check_eq("midrst_pixel", int'(o_pixel), 0);
        repeat (3) cycle_drive(1'b0, 0, 1'b0, 1'b0, 0, 0);
        check_eq("midrst_quiet", res_cnt, 0);
        run_frame(10, 1'b0, 1'b0, 1'b0, 1'b0);
        drain("after_rst", 12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
